// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   scanStateT  : scan FSM states (IDLE, GAPST, ON)
//   SEG_BLANK   : active-low "all segments off" pattern
//   GLYPH_TABLE : active-low {g,f,e,d,c,b,a} glyphs for hex 0..F
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAPST = 2'd1,
        ON    = 2'd2
    } scanStateT;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0011000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/seg7_dec.sv
// Combinational hex-to-glyph decoder.
//   hex : 4-bit hex digit
//   seg : active-low segment pattern {g,f,e,d,c,b,a}
module seg7_dec
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = GLYPH_TABLE[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
//   iCLK, iRST : clock and synchronous active-high reset
//   iDIG       : four hex digits (digit 0 in iDIG[3:0], rightmost)
//   iVALID     : iDIG offered; accepted when iVALID && oREADY
//   oREADY     : pending buffer empty
//   iBLANK     : per-digit force-dark mask (live)
//   iBLINK     : per-digit blink enable (live)
//   iLZS       : leading-zero suppression enable
//   oSEG       : registered active-low segments {g,f,e,d,c,b,a}
//   oAN        : registered active-low digit enables
//   oFRAME     : pulse in the last cycle of the digit-3 slot
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIV          = 50000,
    parameter int GAP          = 16,
    parameter int BLINK_FRAMES = 128
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [15:0] iDIG,
    input  logic        iVALID,
    output logic        oREADY,
    input  logic [3:0]  iBLANK,
    input  logic [3:0]  iBLINK,
    input  logic        iLZS,
    output logic [6:0]  oSEG,
    output logic [3:0]  oAN,
    output logic        oFRAME
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_LEN    = CW'(GAP);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    scanStateT     state;
    scanStateT     nextState;
    logic [CW-1:0] slotCnt;
    logic [CW-1:0] slotNext;
    logic [1:0]    digIdx;
    logic [15:0]   activeVal;
    logic [15:0]   pendVal;
    logic          pendFull;
    logic [FW-1:0] frameCnt;
    logic          blinkPhase;

    logic          accept;
    logic          slotEnd;
    logic          frameNow;
    logic          lzsDark;
    logic          digDark;
    logic [3:0]    curNib;
    logic [6:0]    glyph;

    logic [6:0]    seg_p1;
    logic [3:0]    an_p1;

    // Next-state and slot bookkeeping.
    always_comb begin
        slotEnd   = (slotCnt == SLOT_LAST);
        slotNext  = slotEnd ? '0 : slotCnt + 1'b1;
        accept    = iVALID && !pendFull;
        frameNow  = (state == ON) && (digIdx == 2'd3) && slotEnd;
        nextState = state;
        unique case (state)
            IDLE:      if (accept) nextState = GAPST;
            GAPST, ON: nextState = (slotNext < GAP_LEN) ? GAPST : ON;
            default:   nextState = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) state <= IDLE;
        else      state <= nextState;
    end

    // Counters, value registers and blink phase.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            slotCnt    <= '0;
            digIdx     <= '0;
            activeVal  <= '0;
            pendVal    <= '0;
            pendFull   <= 1'b0;
            frameCnt   <= '0;
            blinkPhase <= 1'b0;
        end else if (state == IDLE) begin
            slotCnt <= '0;
            digIdx  <= '0;
            // The first value bypasses the pending buffer.
            if (accept) activeVal <= iDIG;
        end else begin
            slotCnt <= slotNext;
            if (slotEnd) digIdx <= digIdx + 2'd1;
            if (frameNow) begin
                // Swap only at frame end so a value never shows torn.
                if (pendFull) begin
                    activeVal <= pendVal;
                    pendFull  <= 1'b0;
                end
                if (frameCnt == FRAME_LAST) begin
                    frameCnt   <= '0;
                    blinkPhase <= ~blinkPhase;
                end else begin
                    frameCnt <= frameCnt + 1'b1;
                end
            end
            // accept implies pendFull was clear, so this never collides with the swap.
            if (accept) begin
                pendVal  <= iDIG;
                pendFull <= 1'b1;
            end
        end
    end

    // Darkness of the digit currently being scanned.
    always_comb begin
        curNib  = activeVal[{digIdx, 2'b00} +: 4];
        lzsDark = iLZS && (digIdx != 2'd0) && ((activeVal >> {digIdx, 2'b00}) == 16'h0000);
        digDark = iBLANK[digIdx] || (iBLINK[digIdx] && blinkPhase) || lzsDark;
    end

    seg7_dec uDec (
        .hex (curNib),
        .seg (glyph)
    );

    // Output register stage (p1): one cycle behind the scan state.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            seg_p1 <= SEG_BLANK;
            an_p1  <= 4'hF;
        end else if ((state == ON) && !digDark) begin
            seg_p1 <= glyph;
            an_p1  <= ~(4'b0001 << digIdx);
        end else begin
            seg_p1 <= SEG_BLANK;
            an_p1  <= 4'hF;
        end
    end

    assign oSEG   = seg_p1;
    assign oAN    = an_p1;
    assign oFRAME = frameNow;
    assign oREADY = !pendFull;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    localparam int DIV = 8;
    localparam int GAP = 2;
    localparam int BF  = 2;

    logic        clk;
    logic        iRST;
    logic [15:0] iDIG;
    logic        iVALID;
    logic        oREADY;
    logic [3:0]  iBLANK;
    logic [3:0]  iBLINK;
    logic        iLZS;
    logic [6:0]  oSEG;
    logic [3:0]  oAN;
    logic        oFRAME;

    seg7_scan_ctrl #(.DIV(DIV), .GAP(GAP), .BLINK_FRAMES(BF)) dut (
        .iCLK   (clk),
        .iRST   (iRST),
        .iDIG   (iDIG),
        .iVALID (iVALID),
        .oREADY (oREADY),
        .iBLANK (iBLANK),
        .iBLINK (iBLINK),
        .iLZS   (iLZS),
        .oSEG   (oSEG),
        .oAN    (oAN),
        .oFRAME (oFRAME)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCmp = 0;
    int nBad = 0;
    logic checkEn = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference glyphs, active-low {g..a}.
    logic [6:0] glyphRef [16];
    initial begin
        glyphRef[0]  = 7'b1000000; glyphRef[1]  = 7'b1111001;
        glyphRef[2]  = 7'b0100100; glyphRef[3]  = 7'b0110000;
        glyphRef[4]  = 7'b0011001; glyphRef[5]  = 7'b0010010;
        glyphRef[6]  = 7'b0000010; glyphRef[7]  = 7'b1111000;
        glyphRef[8]  = 7'b0000000; glyphRef[9]  = 7'b0011000;
        glyphRef[10] = 7'b0001000; glyphRef[11] = 7'b0000011;
        glyphRef[12] = 7'b1000110; glyphRef[13] = 7'b0100001;
        glyphRef[14] = 7'b0000110; glyphRef[15] = 7'b0001110;
    end

    // Behavioural model: scan position derived from elapsed cycles since start.
    logic        mScan = 1'b0;
    int          mT = 0;
    logic [15:0] mActive = '0;
    logic [15:0] mPend = '0;
    logic        mPendFull = 1'b0;
    int          mFrames = 0;
    logic [6:0]  eSeg = 7'h7F;
    logic [3:0]  eAn = 4'hF;
    logic        eFrame = 1'b0;
    logic        eReady = 1'b1;

    always @(posedge clk) begin
        int   pos;
        int   dig;
        int   phase;
        logic dark;
        logic acc;
        logic [3:0] nib;
        if (iRST) begin
            mScan = 1'b0; mT = 0; mActive = '0; mPend = '0;
            mPendFull = 1'b0; mFrames = 0; eSeg = 7'h7F; eAn = 4'hF;
        end else if (mScan) begin
            pos   = mT % DIV;
            dig   = (mT / DIV) % 4;
            phase = (mFrames / BF) % 2;
            nib   = mActive[4*dig +: 4];
            dark  = iBLANK[dig] || (iBLINK[dig] && phase == 1) ||
                    (iLZS && dig != 0 && (mActive >> (4*dig)) == 16'h0);
            if (pos >= GAP && !dark) begin
                eSeg = glyphRef[nib];
                eAn  = 4'hF & ~(4'b0001 << dig);
            end else begin
                eSeg = 7'h7F;
                eAn  = 4'hF;
            end
            acc = iVALID && !mPendFull;
            if (pos == DIV-1 && dig == 3) begin
                if (mPendFull) begin
                    mActive   = mPend;
                    mPendFull = 1'b0;
                end
                mFrames++;
            end
            if (acc) begin
                mPend     = iDIG;
                mPendFull = 1'b1;
            end
            mT++;
        end else begin
            eSeg = 7'h7F;
            eAn  = 4'hF;
            if (iVALID) begin
                mActive = iDIG;
                mScan   = 1'b1;
                mT      = 0;
            end
        end
        eFrame = mScan && (mT % DIV == DIV-1) && ((mT / DIV) % 4 == 3);
        eReady = !mPendFull;
    end

    always @(negedge clk) begin
        if (checkEn) begin
            check("seg", {25'd0, oSEG}, {25'd0, eSeg});
            check("an", {28'd0, oAN}, {28'd0, eAn});
            check("frame", {31'd0, oFRAME}, {31'd0, eFrame});
            check("ready", {31'd0, oREADY}, {31'd0, eReady});
            check("anOneLow", {31'd0, ($countones(~oAN) <= 1)}, 32'd1);
        end
    end

    // Offer a value and hold it until accepted; returns at the negedge after accept.
    task automatic offer(input logic [15:0] v);
        int n;
        n = 0;
        iDIG   = v;
        iVALID = 1'b1;
        while (oREADY !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("offerReady", {31'd0, oREADY}, 32'd1);
        @(posedge clk);
        #1 iVALID = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitFor(input string name, input logic [3:0] an, input logic [6:0] seg,
                           output int n);
        n = 0;
        @(negedge clk);
        while (oAN !== an && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({name, "_an"}, {28'd0, oAN}, {28'd0, an});
        check({name, "_seg"}, {25'd0, oSEG}, {25'd0, seg});
    endtask

    task automatic waitFrame(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (oFRAME !== 1'b1 && n < 100);
        check("frameSeen", {31'd0, oFRAME}, 32'd1);
    endtask

    task automatic countWindow(input string name, input int expLit);
        int lit;
        int dark;
        lit = 0;
        dark = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (oAN === 4'b1110) lit++;
            if (oAN === 4'hF) dark++;
        end
        check({name, "_lit"}, lit, expLit);
        check({name, "_dark"}, dark, 32 - expLit);
    endtask

    initial begin
        int n;
        int frameAt;
        iRST = 1'b1; iVALID = 1'b0; iDIG = '0;
        iBLANK = '0; iBLINK = '0; iLZS = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkEn = 1'b1;
        @(negedge clk);
        check("rst_an", {28'd0, oAN}, 32'hF);
        check("rst_seg", {25'd0, oSEG}, 32'h7F);
        check("rst_ready", {31'd0, oREADY}, 32'd1);
        check("rst_frame", {31'd0, oFRAME}, 32'd0);
        iRST = 1'b0;
        repeat (3) @(negedge clk);

        // First value from IDLE, two dark gap cycles then digit 0.
        offer(16'h1234);
        waitFor("d0_1234", 4'b1110, 7'b0011001, n);
        check("gapDark", n, 2);
        waitFor("d3_1234", 4'b0111, 7'b1111001, n);
        waitFrame(n);
        waitFrame(n);
        check("framePeriod", n, 32);

        // Leading-zero suppression.
        iLZS = 1'b1;
        offer(16'h0007);
        waitFrame(n);
        waitFor("lzs7", 4'b1110, 7'b1111000, n);
        countWindow("lzs7win", 6);
        offer(16'h0000);
        waitFrame(n);
        waitFor("lzs0", 4'b1110, 7'b1000000, n);
        countWindow("lzs0win", 6);
        iLZS = 1'b0;

        // Mid-frame accept, held second value.
        waitFrame(n);
        repeat (5) @(negedge clk);
        offer(16'hABCD);
        check("abcdBusy", {31'd0, oREADY}, 32'd0);
        iDIG = 16'h5555;
        iVALID = 1'b1;
        n = 0;
        frameAt = -10;
        while (oREADY !== 1'b1 && n < 100) begin
            if (oFRAME === 1'b1) frameAt = n;
            @(negedge clk);
            n++;
        end
        check("readyAfterFrame", n - frameAt, 1);
        @(posedge clk);
        #1 iVALID = 1'b0;
        waitFor("dGlyph", 4'b1110, 7'b0100001, n);
        check("held5555", {31'd0, oREADY}, 32'd0);
        waitFrame(n);
        waitFor("five", 4'b1110, 7'b0010010, n);

        // Blink: reset for a known phase, then 6 frames.
        iRST = 1'b1;
        @(negedge clk);
        iRST = 1'b0;
        iBLINK = 4'b0001;
        offer(16'h1234);
        for (int f = 0; f < 6; f++) begin
            int cnt;
            int lit;
            cnt = 0;
            lit = 0;
            do begin
                @(negedge clk);
                cnt++;
                if (oAN === 4'b1110) lit++;
            end while (oFRAME !== 1'b1 && cnt < 40);
            if (f > 0) check("blinkFrameLen", cnt, 32);
            check("blinkLit", lit, ((f / 2) % 2 == 1) ? 0 : 6);
        end
        iBLINK = 4'b0000;

        // Reset during ON with a pending value.
        offer(16'h9999);
        waitFrame(n);
        waitFor("nine", 4'b1110, 7'b0011000, n);
        offer(16'h1111);
        check("pendBeforeRst", {31'd0, oREADY}, 32'd0);
        iRST = 1'b1;
        @(negedge clk);
        check("midRst_an", {28'd0, oAN}, 32'hF);
        check("midRst_seg", {25'd0, oSEG}, 32'h7F);
        check("midRst_ready", {31'd0, oREADY}, 32'd1);
        iRST = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (oAN !== 4'hF) n++;
        end
        check("darkAfterRst", n, 0);
        offer(16'h0008);
        waitFor("eight", 4'b1110, 7'b0000000, n);
        repeat (4) @(negedge clk);

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, nBad=%0d", nBad);
        $fatal(1, "watchdog");
    end

endmodule
